uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter command port between NUM_REQ requesters.
- Port shape: 16-bit cmd_in, cmd_vld, cmd_rdy.
- Grants one requester at a time and issues its 16-bit command as a single-cycle cmd_vld pulse.
- Tracks the UART's cmd_rdy busy/idle cycle before the next grant, so commands are never overlapped or dropped.
- Sits between the host-side command sources (CPU regs, DMA, test pattern generator) and the UART core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CMD_W, 16, command width (two UART bytes).
- TIMEOUT, 255, cycles allowed in WAIT_LOW before abort (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  NUM_REQ  per-requester request; held until req_rdy.
- req_data  input  NUM_REQ*CMD_W  packed commands; requester i uses bits [i*CMD_W +: CMD_W].
- req_rdy  output  NUM_REQ  one-hot, one-cycle accept pulse.
- cmd_out  output  CMD_W  command to UART cmd_in.
- cmd_vld  output  1  one-cycle issue pulse to UART.
- cmd_rdy  input  1  UART ready; low while transmitting.
- grant_id  output  $clog2(NUM_REQ)  index of last/current grant.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse on abort (0 when feature disabled).

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - Outputs: cmd_out=0, cmd_vld=0, req_rdy=0, grant_id=0, busy=0, timeout_err=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transfer abandons the command; no req_rdy is re-issued.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If cmd_rdy=1 and |req_vld, pick the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - On that edge: cmd_out<=req_data[g], req_rdy[g]<=1, grant_id<=g, last<=g, cmd_vld<=1, go ISSUE.
  - If cmd_rdy=0, or there is no request, stay in IDLE.
- ISSUE (exactly 1 cycle): cmd_vld=1 and req_rdy[g]=1 are visible together. Next edge: both clear, go WAIT_LOW.
- WAIT_LOW: wait for cmd_rdy=0 (UART accepted the command), then go WAIT_HIGH.
- WAIT_HIGH: wait for cmd_rdy=1 (frame finished), then go IDLE.
- Latency: request in IDLE at edge t gives cmd_vld/req_rdy high during cycle t..t+1. Earliest next grant is 1 cycle after cmd_rdy returns high.
- cmd_out is held stable from grant until the next grant.
- Requester deasserts req_vld the cycle after req_rdy. A still-asserted req_vld is treated as a new request at the next IDLE.
- Simultaneous requests: strict rotation. A requester just served has lowest priority next time, which guarantees no starvation.
- req_vld dropping before grant: withdrawn, no error.
- A request arriving in the same cycle that cmd_rdy rises in WAIT_HIGH is served on the following IDLE cycle.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit (≥$clog2(TIMEOUT+1)) counter runs in WAIT_LOW.
  - If cmd_rdy is still 1 after TIMEOUT cycles, pulse timeout_err for 1 cycle and return to IDLE.
  - The pointer stays advanced; the command is lost.
  - The counter clears on entry to WAIT_LOW.
- Undefined: WAIT_LOW waits forever; timeout_err is tied 0; no counter is instantiated.

Decomposition:
- Shared package uart_pkg:
  - State enum: IDLE=2'd0, ISSUE=2'd1, WAIT_LOW=2'd2, WAIT_HIGH=2'd3.
  - Constant UART_CMD_W=16.
  - Default TIMEOUT value.
- Sub-module uart_rr_pick: combinational round-robin selector.
  - Inputs: req vector and last pointer.
  - Outputs: found flag and index.
  - Reusable for an RX-side consumer arbiter.

Test Plan:
- Single request: req_vld=4'b0001, data=16'hA55A, UART model drops cmd_rdy 1 cycle after cmd_vld and raises it 22 cycles later. Expect one cmd_vld pulse, cmd_out=16'hA55A, req_rdy=4'b0001 in the same cycle, busy high until cmd_rdy returns.
- All four requesting continuously with data 16'h0000/1111/2222/3333. Expect issue order 0,1,2,3,0 and grant_id sequence 0,1,2,3,0, with no two cmd_vld pulses while cmd_rdy=0.
- After serving requester 2, requesters 2 and 3 both request. Expect 3 granted first, then 2.
- cmd_rdy held 0 at start while req_vld=4'b0010. Expect no grant and no cmd_vld until cmd_rdy=1, then grant 1 on the next edge.
- rst asserted during WAIT_HIGH. Expect immediate return of all outputs to 0. After release, requester 0 wins against simultaneous 0 and 3.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=10, cmd_rdy stuck at 1 after cmd_vld. Expect timeout_err pulse 10 cycles after entering WAIT_LOW, then a return to IDLE and the next grant proceeding. Without the macro, expect busy to stay high indefinitely.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART command-path blocks.
//   arb_state_e    : TX arbiter FSM encoding (IDLE, ISSUE, WAIT_LOW, WAIT_HIGH)
//   UART_CMD_W     : width of one UART command (two bytes)
//   UART_ARB_TIMEOUT : default WAIT_LOW abort limit in cycles
//   arb_cnt_width() : width of the WAIT_LOW abort counter for a given limit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } arb_state_e;

  localparam int UART_CMD_W       = 16;
  localparam int UART_ARB_TIMEOUT = 255;

  // At least 8 bits, wider only if the limit needs it.
  function automatic int arb_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. Searches req starting one past the
// previous winner (last+1, last+2, ... modulo NUM_REQ) and returns the first
// set bit, so the most recently served requester has the lowest priority.
// Ports:
//   req   : request vector
//   last  : index of the previous winner
//   found : at least one request is set
//   idx   : index of the winner (0 when found is low)
// -----------------------------------------------------------------------------
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART TX command port between NUM_REQ
// requesters. A grant issues the winner's command as a one-cycle cmd_vld
// pulse together with a one-cycle req_rdy accept, then follows the UART's
// cmd_rdy busy (low) / idle (high) cycle before the next grant.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): abort WAIT_LOW after TIMEOUT
// cycles if the UART never drops cmd_rdy, pulsing timeout_err. Without the
// macro WAIT_LOW waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req_vld     : per-requester request, held until req_rdy
//   req_data    : packed commands, requester i at [i*CMD_W +: CMD_W]
//   req_rdy     : one-hot, one-cycle accept pulse
//   cmd_out     : command to UART, held from grant to next grant
//   cmd_vld     : one-cycle issue pulse to UART
//   cmd_rdy     : UART ready, low while transmitting
//   grant_id    : index of the last/current grant
//   busy        : FSM is outside IDLE
//   timeout_err : one-cycle abort pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CMD_W   = UART_CMD_W,
  parameter  int TIMEOUT = UART_ARB_TIMEOUT,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*CMD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic [CMD_W-1:0]         cmd_out,
  output logic                     cmd_vld,
  input  logic                     cmd_rdy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_e         state_q, state_d;
  logic [CMD_W-1:0]   cmd_out_q, cmd_out_d;
  logic               cmd_vld_q, cmd_vld_d;
  logic [NUM_REQ-1:0] req_rdy_q, req_rdy_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               busy_q, busy_d;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = arb_cnt_width(TIMEOUT);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_vld),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    cmd_out_d  = cmd_out_q;
    cmd_vld_d  = 1'b0;
    req_rdy_d  = '0;
    grant_id_d = grant_id_q;
    last_d     = last_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Only grant while the UART is idle, so a command is never
        // presented on top of a frame still in flight.
        if (cmd_rdy && pick_found) begin
          cmd_out_d           = req_data[pick_idx*CMD_W +: CMD_W];
          req_rdy_d[pick_idx] = 1'b1;
          grant_id_d          = pick_idx;
          last_d              = pick_idx;
          cmd_vld_d           = 1'b1;
          state_d             = ISSUE;
        end
      end

      ISSUE: begin
        state_d = WAIT_LOW;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT_LOW: begin
        // cmd_rdy falling is the UART's acknowledgement of the command.
        if (!cmd_rdy) begin
          state_d = WAIT_HIGH;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Command is lost; last_q keeps the advanced pointer.
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      WAIT_HIGH: begin
        if (cmd_rdy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_out_q  <= '0;
      cmd_vld_q  <= 1'b0;
      req_rdy_q  <= '0;
      grant_id_q <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_out_q  <= cmd_out_d;
      cmd_vld_q  <= cmd_vld_d;
      req_rdy_q  <= req_rdy_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign cmd_out  = cmd_out_q;
  assign cmd_vld  = cmd_vld_q;
  assign req_rdy  = req_rdy_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, CMD_W=16, TIMEOUT=10).
// A cycle table covers reset, cmd_rdy gating and back-to-back grants; short
// hand-written sequences cover rotation, reset mid-frame and the WAIT_LOW
// timeout (UART_ARB_TIMEOUT_EN); a random phase drives queued requesters and
// a simple UART model and compares every grant with a rotation reference.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   cmd_out;
  logic           cmd_vld;
  logic           cmd_rdy;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(
    .NUM_REQ (N),
    .CMD_W   (W),
    .TIMEOUT (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .cmd_out     (cmd_out),
    .cmd_vld     (cmd_vld),
    .cmd_rdy     (cmd_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rotation: first requester after 'last', modulo N; -1 if none.
  function automatic int rr_expect(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset(input bit check_outputs);
    rst     = 1'b1;
    req_vld = '0;
    cmd_rdy = 1'b1;
    repeat (2) tick();
    if (check_outputs) begin
      check("rst_cmd_out", cmd_out, 0);
      check("rst_cmd_vld", cmd_vld, 0);
      check("rst_req_rdy", req_rdy, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
    end
    rst = 1'b0;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic wait_grant(input int budget, output int gid, output logic [W-1:0] d,
                            output bit ok);
    ok  = 1'b0;
    gid = -1;
    d   = '0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (cmd_vld) begin
        ok  = 1'b1;
        gid = int'(grant_id);
        d   = cmd_out;
      end
    end
  endtask

  // Called right after a cmd_vld was observed: UART drops cmd_rdy one cycle
  // later, keeps it low for low_cycles, then raises it.
  task automatic uart_frame(input int low_cycles, inout int overlap);
    tick();
    cmd_rdy = 1'b0;
    repeat (low_cycles) begin
      tick();
      if (cmd_vld) overlap++;
    end
    cmd_rdy = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         rdy;
    logic         vld;
    logic [N-1:0] rr;
    logic [1:0]   gid;
    logic         busy;
    logic [W-1:0] cmd;
  } vec_t;

  vec_t vecs[15];

  logic [W-1:0] rq[N][$];

  initial begin
    int          gid;
    logic [W-1:0] d;
    bit          ok;
    int          overlap;
    int          vld_count;
    bit          all_busy;
    int          exp_order[5];
    logic [W-1:0] exp_data[5];

    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    cmd_rdy  = 1'b1;

    // ---------------- table: gating, back-to-back, late request -----------
    vecs[0]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000};
    vecs[1]  = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000};
    vecs[2]  = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 16'h1111};
    vecs[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b1, 16'h1111};
    vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 16'h1111};
    vecs[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd1, 1'b1, 16'h1111};
    vecs[6]  = '{4'b1000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 16'h1111};
    vecs[7]  = '{4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 16'h3333};
    vecs[8]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 16'h3333};
    vecs[9]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 16'h3333};
    vecs[10] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0, 16'h3333};
    vecs[11] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1, 16'h0000};
    vecs[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 16'h0000};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 16'h0000};

    set_data(16'h0000, 16'h1111, 16'h2222, 16'h3333);
    do_reset(1'b1);
    for (int i = 0; i < 15; i++) begin
      req_vld = vecs[i].req;
      cmd_rdy = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_cmd_vld", i), cmd_vld, vecs[i].vld);
      check($sformatf("vec%0d_req_rdy", i), req_rdy, vecs[i].rr);
      check($sformatf("vec%0d_grant_id", i), grant_id, vecs[i].gid);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d_cmd_out", i), cmd_out, vecs[i].cmd);
    end

    // ---------------- single request, long UART frame ---------------------
    do_reset(1'b0);
    set_data(16'hA55A, 16'h0000, 16'h0000, 16'h0000);
    req_vld = 4'b0001;
    tick();
    check("single_cmd_vld", cmd_vld, 1);
    check("single_cmd_out", cmd_out, 16'hA55A);
    check("single_req_rdy", req_rdy, 4'b0001);
    check("single_busy", busy, 1);
    req_vld   = '0;
    vld_count = 0;
    all_busy  = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    repeat (22) begin
      tick();
      if (cmd_vld) vld_count++;
      if (!busy) all_busy = 1'b0;
    end
    check("single_busy_during_frame", all_busy, 1);
    check("single_no_extra_vld", vld_count, 0);
    cmd_rdy = 1'b1;
    tick();
    check("single_busy_after", busy, 0);
    check("single_cmd_hold", cmd_out, 16'hA55A);

    // ---------------- all four requesting continuously --------------------
    do_reset(1'b0);
    set_data(16'h0000, 16'h1111, 16'h2222, 16'h3333);
    exp_order = '{0, 1, 2, 3, 0};
    exp_data  = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h0000};
    overlap   = 0;
    req_vld   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(50, gid, d, ok);
      check($sformatf("rot_grant%0d_seen", g), ok, 1);
      check($sformatf("rot_grant%0d_id", g), gid, exp_order[g]);
      check($sformatf("rot_grant%0d_data", g), d, exp_data[g]);
      uart_frame(4, overlap);
    end
    check("rot_no_overlap", overlap, 0);

    // ---------------- 2 served, then 2 and 3 compete ----------------------
    do_reset(1'b0);
    overlap = 0;
    req_vld = 4'b0100;
    wait_grant(20, gid, d, ok);
    check("after2_first", gid, 2);
    req_vld = 4'b1100;
    uart_frame(3, overlap);
    wait_grant(20, gid, d, ok);
    check("after2_second", gid, 3);
    req_vld = 4'b0100;
    uart_frame(3, overlap);
    wait_grant(20, gid, d, ok);
    check("after2_third", gid, 2);
    req_vld = '0;
    uart_frame(3, overlap);
    check("after2_no_overlap", overlap, 0);

    // ---------------- reset during WAIT_HIGH ------------------------------
    do_reset(1'b0);
    req_vld = 4'b0100;
    wait_grant(20, gid, d, ok);
    req_vld = '0;
    tick();
    cmd_rdy = 1'b0;
    repeat (2) tick();
    check("rstmid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_cmd_out", cmd_out, 0);
    check("rstmid_grant_id", grant_id, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_req_rdy", req_rdy, 0);
    check("rstmid_cmd_vld", cmd_vld, 0);
    cmd_rdy = 1'b1;
    req_vld = 4'b1001;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rstmid_regrant_vld", cmd_vld, 1);
    check("rstmid_regrant_id", grant_id, 0);
    check("rstmid_regrant_rdy", req_rdy, 4'b0001);
    req_vld = '0;

    // ---------------- cmd_rdy stuck high after cmd_vld --------------------
    do_reset(1'b0);
    req_vld = 4'b0001;
    wait_grant(20, gid, d, ok);
    check("stuck_grant_seen", ok, 1);
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int n_wait;
      n_wait = 0;
      ok     = 1'b0;
      for (int c = 1; c <= 40 && !ok; c++) begin
        tick();
        if (timeout_err) begin
          ok     = 1'b1;
          n_wait = c;
        end
      end
      check("timeout_seen", ok, 1);
      check("timeout_latency", n_wait, 10);
      check("timeout_idle", busy, 0);
      tick();
      check("timeout_pulse_width", timeout_err, 0);
      check("timeout_regrant_vld", cmd_vld, 1);
      check("timeout_regrant_id", grant_id, 0);
    end
`else
    all_busy  = 1'b1;
    vld_count = 0;
    repeat (100) begin
      tick();
      if (!busy) all_busy = 1'b0;
      if (cmd_vld || timeout_err) vld_count++;
    end
    check("stuck_busy_forever", all_busy, 1);
    check("stuck_no_pulses", vld_count, 0);
`endif
    req_vld = '0;

    // ---------------- randomized traffic vs. rotation reference -----------
    begin
      int           model_last, uart_phase, uart_cnt, n_gen, n_served, exp_g;
      bit           done;
      logic [N-1:0] prev_req, popped;
      logic         prev_rdy;

      do_reset(1'b0);
      model_last = N - 1;
      uart_phase = 0;
      uart_cnt   = 0;
      n_gen      = 0;
      n_served   = 0;
      done       = 1'b0;
      for (int c = 0; c < 6000 && !done; c++) begin
        prev_req = req_vld;
        prev_rdy = cmd_rdy;
        popped   = '0;
        tick();

        if (cmd_vld) begin
          exp_g = rr_expect(prev_req, model_last);
          check("rnd_rdy_at_grant", prev_rdy, 1);
          check("rnd_uart_idle", uart_phase, 0);
          check("rnd_grant_id", grant_id, exp_g);
          check("rnd_req_rdy", req_rdy, (exp_g >= 0) ? (1 << exp_g) : 0);
          if (exp_g >= 0 && rq[exp_g].size() > 0) begin
            check("rnd_cmd_out", cmd_out, rq[exp_g][0]);
            void'(rq[exp_g].pop_front());
            popped[exp_g] = 1'b1;
            n_served++;
            model_last = exp_g;
          end
          uart_phase = 1;
          uart_cnt   = $urandom_range(1, 2);
        end else if (uart_phase == 1) begin
          uart_cnt--;
          if (uart_cnt == 0) begin
            cmd_rdy    = 1'b0;
            uart_phase = 2;
            uart_cnt   = $urandom_range(1, 6);
          end
        end else if (uart_phase == 2) begin
          uart_cnt--;
          if (uart_cnt == 0) begin
            cmd_rdy    = 1'b1;
            uart_phase = 0;
          end
        end

        for (int i = 0; i < N; i++) begin
          if (c < 2000 && $urandom_range(0, 59) == 0) begin
            rq[i].push_back(16'($urandom));
            n_gen++;
          end
          req_vld[i] = (rq[i].size() > 0) && !popped[i];
          req_data[i*W +: W] = (rq[i].size() > 0) ? rq[i][0] : 16'h0000;
        end

        if (c >= 2000 && n_served == n_gen && uart_phase == 0 && !busy) done = 1'b1;
      end
      check("rnd_drained", done, 1);
      check("rnd_all_served", n_served, n_gen);
      req_vld = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
